// File: rtl/seq_gcd_wb_pkg.sv
// Shared definitions for the Wishbone GCD engine: register map, CTRL bit
// positions, FSM state encoding and the byte-lane merge helper.
package gcd_pkg;

    localparam logic [2:0] ADR_CTRL   = 3'd0;
    localparam logic [2:0] ADR_OPA    = 3'd1;
    localparam logic [2:0] ADR_OPB    = 3'd2;
    localparam logic [2:0] ADR_RESULT = 3'd3;
    localparam logic [2:0] ADR_CYCLES = 3'd4;

    localparam int CTRL_START  = 0;
    localparam int CTRL_BUSY   = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_DONE   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STRIP,
        ST_ODDA,
        ST_LOOP,
        ST_FINISH
    } gcd_state_e;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] wdat,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) r[8*i +: 8] = wdat[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_gcd_wb_if.sv
// Bundles for the GCD engine: the Wishbone slave bus as seen by a bus master,
// and the start/result handshake between the register block and the core.
interface seq_gcd_wb_if;
    logic        stb;
    logic        cyc;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat_w;
    logic [31:0] adr;
    logic        ack;
    logic [31:0] dat_r;

    modport master (output stb, cyc, we, sel, dat_w, adr, input ack, dat_r);
    modport slave  (input stb, cyc, we, sel, dat_w, adr, output ack, dat_r);
endinterface

interface gcd_core_if #(parameter int WIDTH = 32);
    logic             start;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (output start, opa, opb, input busy, done, result);
    modport slave  (input start, opa, opb, output busy, done, result);
endinterface

// File: rtl/gcd_stein_core.sv
// Binary (Stein) GCD engine: shift/subtract only, one step per clock.
// done is high for the single cycle spent in FINISH, alongside result.
module gcd_stein_core
    import gcd_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    gcd_core_if.slave  core
);

    localparam int KW = $clog2(WIDTH);

    gcd_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [KW-1:0]    k_q, k_d;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        k_d     = k_q;
        case (state_q)
            ST_IDLE: begin
                if (core.start) begin
                    k_d = '0;
                    // A zero operand makes the other one the answer: a|b covers all three cases.
                    if (core.opa == '0 || core.opb == '0) begin
                        a_d     = core.opa | core.opb;
                        state_d = ST_FINISH;
                    end else begin
                        a_d     = core.opa;
                        b_d     = core.opb;
                        state_d = ST_STRIP;
                    end
                end
            end
            ST_STRIP: begin
                if (!a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + 1'b1;
                end else begin
                    state_d = ST_ODDA;
                end
            end
            ST_ODDA: begin
                if (!a_q[0]) a_d = a_q >> 1;
                else         state_d = ST_LOOP;
            end
            ST_LOOP: begin
                if (b_q == '0) begin
                    state_d = ST_FINISH;
                end else if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q > b_q) begin
                    a_d = b_q;
                    b_d = a_q;
                end else begin
                    b_d = b_q - a_q;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
        a_q <= a_d;
        b_q <= b_d;
    end

    assign core.busy   = (state_q != ST_IDLE);
    assign core.done   = (state_q == ST_FINISH);
    assign core.result = a_q << k_q;

endmodule

// File: rtl/seq_gcd_wb.sv
// Wishbone register front-end for the Stein GCD core. Defining
// GCD_CYCLE_CNT_EN builds the CYCLES counter; otherwise CYCLES reads 0.
module seq_gcd_wb
    import gcd_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_dat_i,
    input  logic [31:0]      wbs_adr_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic [WIDTH-1:0] gcd_o,
    output logic             busy_o,
    output logic             irq_o
);

    gcd_core_if #(.WIDTH(WIDTH)) core_if ();

    logic             ack_q, ack_d;
    logic [31:0]      dat_o_q, dat_o_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             irq_en_q, irq_en_d;
    logic             busy, start, accept, wr_ctrl;
    logic [2:0]       adr;
    logic [31:0]      cycles_rd;
    logic             unused_adr;

    assign unused_adr = &{1'b0, wbs_adr_i[31:5], wbs_adr_i[1:0]};
    assign adr        = wbs_adr_i[4:2];
    assign busy       = core_if.busy;
    assign accept     = wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign wr_ctrl    = accept & wbs_we_i & (adr == ADR_CTRL) & wbs_sel_i[0];
    assign start      = wr_ctrl & wbs_dat_i[CTRL_START] & ~busy;

    assign core_if.start = start;
    assign core_if.opa   = opa_q;
    assign core_if.opb   = opb_q;

    gcd_stein_core #(.WIDTH(WIDTH)) u_core (
        .clk  (wb_clk_i),
        .rst  (wb_rst_i),
        .core (core_if.slave)
    );

    always_comb begin
        ack_d    = accept;
        dat_o_d  = '0;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        done_d   = done_q;
        irq_en_d = irq_en_q;
        if (wr_ctrl) begin
            irq_en_d = wbs_dat_i[CTRL_IRQ_EN];
            if (wbs_dat_i[CTRL_DONE]) done_d = 1'b0;
        end
        if (accept && wbs_we_i && !busy) begin
            if (adr == ADR_OPA) opa_d = WIDTH'(byte_merge(32'(opa_q), wbs_dat_i, wbs_sel_i));
            if (adr == ADR_OPB) opb_d = WIDTH'(byte_merge(32'(opb_q), wbs_dat_i, wbs_sel_i));
        end
        // Completion is applied last so it overrides a DONE clear in the same cycle.
        if (core_if.done) begin
            result_d = core_if.result;
            done_d   = 1'b1;
        end
        if (accept && !wbs_we_i) begin
            case (adr)
                ADR_CTRL: begin
                    dat_o_d[CTRL_BUSY]   = busy;
                    dat_o_d[CTRL_IRQ_EN] = irq_en_q;
                    dat_o_d[CTRL_DONE]   = done_q;
                end
                ADR_OPA:    dat_o_d = 32'(opa_q);
                ADR_OPB:    dat_o_d = 32'(opb_q);
                ADR_RESULT: dat_o_d = 32'(result_q);
                ADR_CYCLES: dat_o_d = cycles_rd;
                default:    dat_o_d = '0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            dat_o_q  <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            ack_q    <= ack_d;
            dat_o_q  <= dat_o_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            done_q   <= done_d;
            irq_en_q <= irq_en_d;
        end
    end

`ifdef GCD_CYCLE_CNT_EN
    logic [31:0] cycles_q, cycles_d;

    always_comb begin
        cycles_d = cycles_q;
        if (start)                        cycles_d = '0;
        else if (busy && cycles_q != '1)  cycles_d = cycles_q + 32'd1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) cycles_q <= '0;
        else          cycles_q <= cycles_d;
    end

    assign cycles_rd = cycles_q;
`else
    assign cycles_rd = '0;
`endif

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_o_q;
    assign gcd_o     = result_q;
    assign busy_o    = busy;
    assign irq_o     = done_q & irq_en_q;

endmodule

// File: tb/tb_seq_gcd_wb.sv
// Self-checking bench for seq_gcd_wb: directed register/IRQ/reset scenarios
// plus random operand pairs checked against a Euclid reference model.
module tb_seq_gcd_wb;

    localparam int W = 32;
    localparam logic [31:0] A_CTRL = 32'h00, A_OPA = 32'h04, A_OPB = 32'h08;
    localparam logic [31:0] A_RES  = 32'h0C, A_CYC = 32'h10, A_UNM = 32'h14;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] gcd_o;
    logic         busy_o, irq_o;
    int           total = 0;
    int           bad   = 0;

    always #5 clk = ~clk;

    seq_gcd_wb_if bus ();

    seq_gcd_wb #(.WIDTH(W)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_stb_i (bus.stb),
        .wbs_cyc_i (bus.cyc),
        .wbs_we_i  (bus.we),
        .wbs_sel_i (bus.sel),
        .wbs_dat_i (bus.dat_w),
        .wbs_adr_i (bus.adr),
        .wbs_ack_o (bus.ack),
        .wbs_dat_o (bus.dat_r),
        .gcd_o     (gcd_o),
        .busy_o    (busy_o),
        .irq_o     (irq_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] gcd_ref(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output logic [31:0] rdat);
        bit ok = 0;
        rdat      = '0;
        bus.stb   = 1'b1;
        bus.cyc   = 1'b1;
        bus.we    = we;
        bus.adr   = adr;
        bus.dat_w = dat;
        bus.sel   = sel;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (bus.ack) begin
                ok   = 1;
                rdat = bus.dat_r;
            end
        end
        bus.stb = 1'b0;
        bus.cyc = 1'b0;
        bus.we  = 1'b0;
        if (!ok) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel = 4'hF);
        logic [31:0] dummy;
        xfer(1'b1, adr, dat, sel, dummy);
    endtask

    task automatic rd(input logic [31:0] adr, output logic [31:0] dat);
        xfer(1'b0, adr, 32'd0, 4'hF, dat);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy_o && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy_o) chk("busy_timeout", 32'd0, 32'd1);
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ctrl, output int n);
        wr(A_OPA, a);
        wr(A_OPB, b);
        wr(A_CTRL, ctrl);
        wait_idle(n);
    endtask

    initial begin
        logic [31:0] d, a, b;
        int          n, n48;

        bus.stb = 0; bus.cyc = 0; bus.we = 0; bus.sel = 0; bus.dat_w = 0; bus.adr = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_dat", bus.dat_r, 32'd0);
        rst = 1'b0;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_irq", 32'(irq_o), 32'd0);
        chk("rst_gcd", 32'(gcd_o), 32'd0);
        rd(A_CTRL, d); chk("rst_ctrl", d, 32'd0);
        rd(A_OPA, d);  chk("rst_opa", d, 32'd0);
        rd(A_RES, d);  chk("rst_result", d, 32'd0);
        rd(A_CYC, d);  chk("rst_cycles", d, 32'd0);

        // 48,18 with IRQ disabled
        run(32'd48, 32'd18, 32'h1, n48);
        chk("g48_bound", 32'(n48 <= 3*W+4), 32'd1);
        rd(A_CTRL, d); chk("g48_ctrl", d, 32'h4);
        rd(A_RES, d);  chk("g48_result", d, 32'd6);
        chk("g48_gcd_o", 32'(gcd_o), 32'd6);
        chk("g48_irq", 32'(irq_o), 32'd0);
        rd(A_CYC, d);
`ifdef GCD_CYCLE_CNT_EN
        chk("g48_cycles_range", 32'(d != 0 && d <= 100), 32'd1);
`else
        chk("g48_cycles_zero", d, 32'd0);
`endif

        // DONE-clear landing on the completion edge must lose to the set
        wr(A_CTRL, 32'h5);
        repeat (n48 - 1) begin
            @(posedge clk);
            #1;
        end
        wr(A_CTRL, 32'h4);
        rd(A_CTRL, d); chk("done_wins", d, 32'h4);

        // zero operands
        run(32'd0, 32'd7, 32'h5, n);
        chk("z07_bound", 32'(n <= 3), 32'd1);
        rd(A_RES, d); chk("z07_result", d, 32'd7);
        run(32'd7, 32'd0, 32'h5, n);
        chk("z70_bound", 32'(n <= 3), 32'd1);
        rd(A_RES, d); chk("z70_result", d, 32'd7);
        run(32'd0, 32'd0, 32'h5, n);
        chk("z00_bound", 32'(n <= 3), 32'd1);
        rd(A_RES, d); chk("z00_result", d, 32'd0);
        rd(A_CTRL, d); chk("z00_ctrl", d, 32'h4);

        // large powers of two with IRQ enabled
        wr(A_OPA, 32'h8000_0000);
        wr(A_OPB, 32'hC000_0000);
        wr(A_CTRL, 32'h7);
        chk("pow_irq_cleared", 32'(irq_o), 32'd0);
        wait_idle(n);
        chk("pow_bound", 32'(n <= 3*W+4), 32'd1);
        rd(A_RES, d); chk("pow_result", d, 32'h4000_0000);
        chk("pow_irq_set", 32'(irq_o), 32'd1);
        wr(A_CTRL, 32'h6);
        chk("pow_irq_ack", 32'(irq_o), 32'd0);
        rd(A_CTRL, d); chk("pow_ctrl", d, 32'h2);

        // writes while busy are ignored
        wr(A_OPA, 32'd1071);
        wr(A_OPB, 32'd462);
        wr(A_CTRL, 32'h5);
        rd(A_CTRL, d); chk("busy_ctrl", d, 32'h1);
        wr(A_OPA, 32'd5);
        wr(A_CTRL, 32'h1);
        wait_idle(n);
        rd(A_RES, d); chk("busy_result", d, 32'd21);
        rd(A_OPA, d); chk("busy_opa", d, 32'd1071);

        // byte-lane merge and unmapped offset
        wr(A_OPA, 32'hAABB_CCDD);
        wr(A_OPA, 32'h1122_3344, 4'b0101);
        rd(A_OPA, d); chk("sel_merge", d, 32'hAA22_CC44);
        wr(A_UNM, 32'hFFFF_FFFF);
        rd(A_UNM, d); chk("unmapped", d, 32'd0);

        // reset during an operation
        wr(A_OPA, 32'd48);
        wr(A_OPB, 32'd18);
        wr(A_CTRL, 32'h7);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_gcd_o", 32'(gcd_o), 32'd0);
        rd(A_RES, d);  chk("abort_result", d, 32'd0);
        rd(A_CTRL, d); chk("abort_ctrl", d, 32'd0);
        run(32'd48, 32'd18, 32'h5, n);
        rd(A_RES, d);  chk("abort_rerun", d, 32'd6);

        // random pairs against the reference model
        for (int i = 0; i < 24; i++) begin
            a = $urandom >> $urandom_range(0, 31);
            b = $urandom >> $urandom_range(0, 31);
            if (i % 8 == 0) a = 32'd0;
            if (i % 6 == 1) begin
                a = a << $urandom_range(0, 8);
                b = b << $urandom_range(0, 8);
            end
            run(a, b, 32'h5, n);
            rd(A_RES, d);
            chk($sformatf("rand%0d_result", i), d, gcd_ref(a, b));
            chk($sformatf("rand%0d_gcd_o", i), 32'(gcd_o), gcd_ref(a, b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
